// File: rtl/mmss_pkg.sv
// Shared types and constants for the minutes:seconds BCD counter stage.
package mmss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_TERM  = 2'd2,
    ST_ALARM = 2'd3
  } mmss_state_t;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_LD  = 1;
  localparam int CTRL_RST = 2;
  localparam int CTRL_UP  = 3;
  localparam int CTRL_BU  = 4;

  localparam logic [3:0] MAX_TENS = 4'd5;
  localparam logic [3:0] MAX_ONES = 4'd9;

  localparam logic [15:0] TERM_UP     = 16'h5959;
  localparam logic [15:0] TERM_DN     = 16'h0000;
  localparam logic [15:0] PRE_TERM_UP = 16'h5958;
  localparam logic [15:0] PRE_TERM_DN = 16'h0001;

  function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/mmss_counter_bcd_digit.sv
// One BCD digit: clear, clamped load, increment/decrement with programmable
// maximum, and combinational carry/borrow out for chaining.
module bcd_digit
  import mmss_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic [3:0] max_val,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] value,
  output logic       carry,
  output logic       borrow
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 4'd0;
    end else if (clr) begin
      value <= 4'd0;
    end else if (load) begin
      value <= clamp_digit(load_val, max_val);
    end else if (inc) begin
      value <= (value == max_val) ? 4'd0 : value + 4'd1;
    end else if (dec) begin
      value <= (value == 4'd0) ? max_val : value - 4'd1;
    end
  end

  assign carry  = inc & (value == max_val);
  assign borrow = dec & (value == 4'd0);

endmodule

// File: rtl/mmss_counter.sv
// 00:00-59:59 BCD up/down counter with terminal flag, done pulse and buzzer.
// Define MMSS_WRAP_EN to let the counter wrap at terminal and keep running.
module mmss_counter
  import mmss_pkg::*;
#(
  parameter int BUZZ_TICKS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [4:0]  ctrl,
  input  logic [15:0] load_val,
  output logic [15:0] digits,
  output logic        at_term,
  output logic        done,
  output logic        buzz,
  output logic [1:0]  dbg_state
);

  localparam int BW = $clog2(BUZZ_TICKS + 1);

  mmss_state_t   state_q, state_d;
  logic [BW-1:0] buzz_cnt;
  logic          en, up, bu, do_rst, do_ld, hold;
  logic          term_next, cnt_en, inc0, dec0, wrap_ev, done_ev;
  logic          c0, c1, c2, c3, b0, b1, b2, b3;

  assign en     = ctrl[CTRL_EN];
  assign up     = ctrl[CTRL_UP];
  assign bu     = ctrl[CTRL_BU];
  assign do_rst = ctrl[CTRL_RST];
  assign do_ld  = ctrl[CTRL_LD] & ~do_rst;
  assign hold   = do_rst | ctrl[CTRL_LD];

  assign at_term   = up ? (digits == TERM_UP) : (digits == TERM_DN);
  assign term_next = up ? (digits == PRE_TERM_UP) : (digits == PRE_TERM_DN);

`ifdef MMSS_WRAP_EN
  assign cnt_en = (state_q == ST_RUN) & en & tick & ~hold;
`else
  assign cnt_en = (state_q == ST_RUN) & en & tick & ~hold & ~at_term;
`endif

  assign inc0 = cnt_en & up;
  assign dec0 = cnt_en & ~up;

  // Ripple chain: s_ones -> s_tens -> m_ones -> m_tens.
  bcd_digit u_s_ones (
    .clk(clk), .rst_n(rst_n), .clr(do_rst), .load(do_ld),
    .load_val(load_val[3:0]), .max_val(MAX_ONES),
    .inc(inc0), .dec(dec0), .value(digits[3:0]), .carry(c0), .borrow(b0)
  );
  bcd_digit u_s_tens (
    .clk(clk), .rst_n(rst_n), .clr(do_rst), .load(do_ld),
    .load_val(load_val[7:4]), .max_val(MAX_TENS),
    .inc(c0), .dec(b0), .value(digits[7:4]), .carry(c1), .borrow(b1)
  );
  bcd_digit u_m_ones (
    .clk(clk), .rst_n(rst_n), .clr(do_rst), .load(do_ld),
    .load_val(load_val[11:8]), .max_val(MAX_ONES),
    .inc(c1), .dec(b1), .value(digits[11:8]), .carry(c2), .borrow(b2)
  );
  bcd_digit u_m_tens (
    .clk(clk), .rst_n(rst_n), .clr(do_rst), .load(do_ld),
    .load_val(load_val[15:12]), .max_val(MAX_TENS),
    .inc(c2), .dec(b2), .value(digits[15:12]), .carry(c3), .borrow(b3)
  );

  // A roll-over out of the top digit only happens when counting off terminal,
  // which is possible only in wrap mode; it is reported as a terminal event.
  assign wrap_ev = c3 | b3;
  assign done_ev = (cnt_en & term_next) | wrap_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_ev;
    end
  end

`ifdef MMSS_WRAP_EN
  always_comb begin
    state_d = state_q;
    if (hold) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (en) state_d = ST_RUN;
        ST_RUN:  if (!en) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Buzzer runs alongside counting, armed one clk after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buzz_cnt <= '0;
    end else if (hold || !en) begin
      buzz_cnt <= '0;
    end else if (done && bu) begin
      buzz_cnt <= BW'(BUZZ_TICKS);
    end else if (tick && buzz_cnt != '0) begin
      buzz_cnt <= buzz_cnt - BW'(1);
    end
  end

  assign buzz = (buzz_cnt != '0);
`else
  always_comb begin
    state_d = state_q;
    if (hold) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (en && !at_term) state_d = ST_RUN;
        ST_RUN: begin
          // A direction change can make the held value terminal without a tick.
          if (!en)                        state_d = ST_IDLE;
          else if (cnt_en && term_next)   state_d = ST_TERM;
          else if (at_term)               state_d = ST_TERM;
        end
        ST_TERM:  state_d = bu ? ST_ALARM : ST_IDLE;
        ST_ALARM: begin
          if (!en)                                state_d = ST_IDLE;
          else if (tick && buzz_cnt == BW'(1))    state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buzz_cnt <= '0;
    end else if (hold) begin
      buzz_cnt <= '0;
    end else if (state_q == ST_TERM) begin
      buzz_cnt <= BW'(BUZZ_TICKS);
    end else if (state_q == ST_ALARM && tick && buzz_cnt != '0) begin
      buzz_cnt <= buzz_cnt - BW'(1);
    end
  end

  assign buzz = (state_q == ST_ALARM);
`endif

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mmss_counter.sv
// Directed bench for mmss_counter: drivers push expected outputs into a queue,
// a negedge monitor pops and compares.
module tb_mmss_counter;
  import mmss_pkg::*;

  localparam int W = 21;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [4:0]  ctrl;
  logic [15:0] load_val;
  logic [15:0] digits;
  logic        at_term, done, buzz;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] mon_e, mon_got;
  string        mon_nm;

  // clock / reset
  always #5 clk = ~clk;

  mmss_counter #(.BUZZ_TICKS(5)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ctrl(ctrl), .load_val(load_val),
    .digits(digits), .at_term(at_term), .done(done), .buzz(buzz),
    .dbg_state(dbg_state)
  );

  // expected word: {state, buzz, done, at_term, digits}
  task automatic push(input logic [15:0] d, input logic a, input logic dn,
                      input logic bz, input logic [1:0] st, input string nm);
    exp_q.push_back({st, bz, dn, a, d});
    name_q.push_back(nm);
  endtask

  task automatic step(input logic t, input logic [4:0] c, input logic [15:0] lv,
                      input logic [15:0] d, input logic a, input logic dn,
                      input logic bz, input logic [1:0] st, input string nm);
    tick = t;
    ctrl = c;
    load_val = lv;
    @(posedge clk);
    #1;
    push(d, a, dn, bz, st, nm);
    tick = 1'b0;
    @(negedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_got = {dbg_state, buzz, done, at_term, digits};
      checks++;
      if (mon_got !== mon_e) begin
        errors++;
        $display("FAIL %s: got st=%0d buzz=%b done=%b at_term=%b digits=%h, expected st=%0d buzz=%b done=%b at_term=%b digits=%h",
                 mon_nm, mon_got[20:19], mon_got[18], mon_got[17], mon_got[16], mon_got[15:0],
                 mon_e[20:19], mon_e[18], mon_e[17], mon_e[16], mon_e[15:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    tick = 1'b0;
    ctrl = 5'b01000;
    load_val = 16'h0000;
    #1;
    push(16'h0000, 1'b0, 1'b0, 1'b0, ST_IDLE, "reset_state");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // down from 0000: already terminal, run refused
    step(1, 5'b00001, 16'h0000, 16'h0000, 1, 0, 0, ST_IDLE, "idle_at_term_a");
    step(1, 5'b00001, 16'h0000, 16'h0000, 1, 0, 0, ST_IDLE, "idle_at_term_b");

    // up count with second/minute carry; tick with load is discarded
    step(1, 5'b00010, 16'h0058, 16'h0058, 0, 0, 0, ST_IDLE, "load_0058");
    step(0, 5'b01001, 16'h0000, 16'h0058, 0, 0, 0, ST_RUN,  "run_up");
    step(1, 5'b01001, 16'h0000, 16'h0059, 0, 0, 0, ST_RUN,  "up_0059");
    step(1, 5'b01001, 16'h0000, 16'h0100, 0, 0, 0, ST_RUN,  "up_0100");
    step(0, 5'b01001, 16'h0000, 16'h0100, 0, 0, 0, ST_RUN,  "hold_0100");
    step(1, 5'b01000, 16'h0000, 16'h0100, 0, 0, 0, ST_IDLE, "disable_holds");

    // down to terminal with buzzer for 5 ticks
    step(0, 5'b00010, 16'h0002, 16'h0002, 0, 0, 0, ST_IDLE,  "load_0002");
    step(0, 5'b10001, 16'h0000, 16'h0002, 0, 0, 0, ST_RUN,   "run_dn_bu");
    step(1, 5'b10001, 16'h0000, 16'h0001, 0, 0, 0, ST_RUN,   "dn_0001");
    step(1, 5'b10001, 16'h0000, 16'h0000, 1, 1, 0, ST_TERM,  "dn_0000_done");
    step(0, 5'b10001, 16'h0000, 16'h0000, 1, 0, 1, ST_ALARM, "alarm_enter");
    step(1, 5'b10001, 16'h0000, 16'h0000, 1, 0, 1, ST_ALARM, "alarm_t1");
    step(0, 5'b10001, 16'h0000, 16'h0000, 1, 0, 1, ST_ALARM, "alarm_gap");
    step(1, 5'b10001, 16'h0000, 16'h0000, 1, 0, 1, ST_ALARM, "alarm_t2");
    step(1, 5'b10001, 16'h0000, 16'h0000, 1, 0, 1, ST_ALARM, "alarm_t3");
    step(1, 5'b10001, 16'h0000, 16'h0000, 1, 0, 1, ST_ALARM, "alarm_t4");
    step(1, 5'b10001, 16'h0000, 16'h0000, 1, 0, 0, ST_IDLE,  "alarm_t5_end");
    step(1, 5'b10001, 16'h0000, 16'h0000, 1, 0, 0, ST_IDLE,  "idle_refused");

    // loaded terminal value when counting up
    step(0, 5'b01010, 16'h5959, 16'h5959, 1, 0, 0, ST_IDLE, "load_5959");
`ifdef MMSS_WRAP_EN
    step(1, 5'b01001, 16'h0000, 16'h5959, 1, 0, 0, ST_RUN,  "wrap_run");
    step(1, 5'b01001, 16'h0000, 16'h0000, 0, 1, 0, ST_RUN,  "wrap_0000");
`else
    step(1, 5'b01001, 16'h0000, 16'h5959, 1, 0, 0, ST_IDLE, "term_refused_a");
    step(1, 5'b01001, 16'h0000, 16'h5959, 1, 0, 0, ST_IDLE, "term_refused_b");
`endif

    // out-of-range preset clamps per digit
    step(0, 5'b00010, 16'h7A9F, 16'h5959, 0, 0, 0, ST_IDLE, "clamp_7a9f");

    // borrow across s_tens, then tick coinciding with reset
    step(0, 5'b00010, 16'h0010, 16'h0010, 0, 0, 0, ST_IDLE, "load_0010");
    step(0, 5'b00001, 16'h0000, 16'h0010, 0, 0, 0, ST_RUN,  "run_dn");
    step(1, 5'b00001, 16'h0000, 16'h0009, 0, 0, 0, ST_RUN,  "dn_0009");
    step(1, 5'b00101, 16'h0000, 16'h0000, 1, 0, 0, ST_IDLE, "tick_and_reset");

    // async reset in the middle of the alarm
    step(0, 5'b00010, 16'h0001, 16'h0001, 0, 0, 0, ST_IDLE,  "load_0001");
    step(0, 5'b10001, 16'h0000, 16'h0001, 0, 0, 0, ST_RUN,   "run2");
    step(1, 5'b10001, 16'h0000, 16'h0000, 1, 1, 0, ST_TERM,  "dn2_done");
    step(0, 5'b10001, 16'h0000, 16'h0000, 1, 0, 1, ST_ALARM, "alarm2");
    step(1, 5'b10001, 16'h0000, 16'h0000, 1, 0, 1, ST_ALARM, "alarm2_t1");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    push(16'h0000, 1'b1, 1'b0, 1'b0, ST_IDLE, "async_rst_alarm");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 5'b00000, 16'h0000, 16'h0000, 1, 0, 0, ST_IDLE, "post_reset_idle");

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
